// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider with a start/done handshake.
// One shift-and-trial-subtract step per clock; divide-by-zero short-cuts straight to DONE.
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on start
  // RUN   | one trial-subtract step per clock, WIDTH steps
  // DONE  | done pulse for one cycle, results valid
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r_sh, t, r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             accept, last_step;

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Partial remainder is always below the divisor, so only WIDTH bits are stored;
  // the shifted value and trial difference are WIDTH+1 bits wide.
  always_comb begin
    r_sh  = {r, q[WIDTH-1]};
    t     = r_sh + ~{1'b0, dvs} + {{WIDTH{1'b0}}, 1'b1};
    r_nxt = t[WIDTH] ? r_sh : t;
    q_nxt = {q[WIDTH-2:0], ~t[WIDTH]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:  if (last_step) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvs         <= '0;
      r           <= '0;
      q           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvs         <= divisor;
      r           <= '0;
      q           <= dividend;
      cnt         <= '0;
      div_by_zero <= (divisor == '0);
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      r   <= r_nxt[WIDTH-1:0];
      q   <= q_nxt;
      cnt <= cnt + CW'(1);
      if (last_step) begin
        quotient  <= q_nxt;
        remainder <= r_nxt[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=4): directed cases, handshake,
// abort, exhaustive sweep and random operands against a plain-arithmetic model.
module tb_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;

  int n_chk = 0;
  int n_fail = 0;

  restoring_divider #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts negedges until done is seen (bounded); returns the count.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b);
    int n;
    int eq, er, lat;
    eq  = (b == 0) ? 15 : a / b;
    er  = (b == 0) ? a : a % b;
    lat = (b == 0) ? 1 : 5;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_after_start", busy, 1);
    end while (!done && n < 40);
    chk("latency", n, lat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, (b == 0));
    if (b != 0) begin
      chk("invariant", quotient * b + remainder, a);
      chk("rem_lt_div", (remainder < b), 1);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    chk("quotient_hold", quotient, eq);
  endtask

  initial begin
    int n, seen;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    // Directed cases
    run_op(4'd13, 4'd3);
    run_op(4'd15, 4'd1);
    run_op(4'd5,  4'd7);
    run_op(4'd15, 4'd15);
    run_op(4'd0,  4'd9);
    run_op(4'd9,  4'd0);
    run_op(4'd6,  4'd2);

    // Start while busy is ignored; held start accepted in first IDLE cycle after DONE
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dividend = 4'd8; divisor = 4'd2; start = 1'b1;
    wait_done(n);
    chk("ignored_latency", n, 3);
    chk("ignored_quotient", quotient, 4);
    chk("ignored_remainder", remainder, 1);
    wait_done(n);
    chk("held_start_gap", n, 6);
    chk("held_quotient", quotient, 4);
    chk("held_remainder", remainder, 0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Asynchronous abort mid-RUN
    dividend = 4'd14; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(4'(a), 4'(b));

    // Random operands
    for (int i = 0; i < 40; i++)
      run_op(4'($urandom_range(15)), 4'($urandom_range(15)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
